// File: rtl/mac_dot_pipe.sv
// -----------------------------------------------------------------------------
// mac_dot_pipe
//
// Pipelined unsigned multiply-accumulate engine that forms dot products of
// DOT_LEN terms (or fewer, when a term is flagged with in_last). Terms enter
// through a valid/ready handshake and complete dot products leave through a
// second valid/ready handshake, one result per dot product.
//
// Pipeline:
//   p1  : registered product dataa*datab plus its last flag and valid
//   p2  : accumulation of the p1 product into the running sum; a final term
//         hands the completed sum to the p2 output holding register
//   out : result/overflow registers presented to the consumer
// A final term accepted at edge N shows out_valid after edge N+2.
//
// Backpressure is global: when a result is present and not being consumed
// (out_valid & ~out_ready) every stage holds, and in_ready drops.
//
// Parameters:
//   LPM_WIDTHA : width of unsigned operand dataa
//   LPM_WIDTHB : width of unsigned operand datab
//   ACC_WIDTH  : accumulator/result width, must be >= LPM_WIDTHA+LPM_WIDTHB
//   DOT_LEN    : terms per dot product, 2..256
//   SATURATE   : 0 = wrap modulo 2^ACC_WIDTH, 1 = clamp to all-ones
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : term present on dataa/datab/in_last
//   in_ready  : term accepted when in_valid & in_ready
//   dataa     : operand A (unsigned)
//   datab     : operand B (unsigned)
//   in_last   : this term closes the dot product early
//   out_valid : result/overflow present
//   out_ready : result consumed when out_valid & out_ready
//   result    : dot-product sum
//   overflow  : the sum exceeded 2^ACC_WIDTH-1 at some point in this product
// -----------------------------------------------------------------------------
module mac_dot_pipe #(
  parameter int LPM_WIDTHA = 9,
  parameter int LPM_WIDTHB = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int DOT_LEN    = 4,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LPM_WIDTHA-1:0] dataa,
  input  logic [LPM_WIDTHB-1:0] datab,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  overflow
);

  localparam int PW = LPM_WIDTHA + LPM_WIDTHB;  // full product width
  localparam int SW = ACC_WIDTH + 1;            // sum width incl. carry
  localparam int CW = $clog2(DOT_LEN);          // term counter width
  localparam logic [CW-1:0] LAST_CNT = CW'(DOT_LEN - 1);

  // Sum of the running accumulator and a zero-extended product; the top bit
  // is the carry out of bit ACC_WIDTH-1.
  function automatic logic [SW-1:0] add_ext(input logic [ACC_WIDTH-1:0] acc,
                                            input logic [PW-1:0]        prod);
    add_ext = {1'b0, acc} + SW'(prod);
  endfunction

  // Next accumulator value: wrapped sum, or all-ones once the product has
  // overflowed in saturating mode.
  function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic [SW-1:0] sum,
                                                   input logic          ovf);
    if (SATURATE != 0 && ovf)
      sat_acc = '1;
    else
      sat_acc = sum[ACC_WIDTH-1:0];
  endfunction

  logic                 w_stall;
  logic                 w_adv;
  logic                 w_accept;

  logic                 r_vld_p1;
  logic [PW-1:0]        r_prod_p1;
  logic                 r_last_p1;

  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_sticky;
  logic [CW-1:0]        r_cnt;
  logic [SW-1:0]        w_sum;
  logic                 w_ovf;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic                 w_final;

  logic                 r_vld_p2;
  logic [ACC_WIDTH-1:0] r_sum_p2;
  logic                 r_ovf_p2;

  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_result;
  logic                 r_overflow;

  // Whole pipeline advances together; a pending unconsumed result freezes it.
  assign w_stall  = r_out_valid & ~out_ready;
  assign w_adv    = ~w_stall;
  assign w_accept = in_valid & w_adv;
  assign in_ready = w_adv;

  // ---- stage p1: product register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_prod_p1 <= PW'(dataa) * PW'(datab);
      r_last_p1 <= in_last;
    end
  end

  // ---- stage p2: accumulation ----
  assign w_sum     = add_ext(r_acc, r_prod_p1);
  assign w_ovf     = r_sticky | w_sum[ACC_WIDTH];
  assign w_acc_nxt = sat_acc(w_sum, w_ovf);
  assign w_final   = r_last_p1 | (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_vld_p2 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p2 <= r_vld_p1 & w_final;
      if (r_vld_p1) begin
        if (w_final) begin
          // Completed sum moves to p2; the next term starts a fresh product.
          r_acc    <= '0;
          r_sticky <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_acc    <= w_acc_nxt;
          r_sticky <= w_ovf;
          r_cnt    <= r_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv && r_vld_p1 && w_final) begin
      r_sum_p2 <= w_acc_nxt;
      r_ovf_p2 <= w_ovf;
    end
  end

  // ---- output stage: result registers ----
  // A new result may replace one being consumed in the same edge, so
  // out_valid stays high across back-to-back results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
    end else if (w_adv && r_vld_p2) begin
      r_out_valid <= 1'b1;
      r_result    <= r_sum_p2;
      r_overflow  <= r_ovf_p2;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for mac_dot_pipe. Three instances share one stimulus stream:
//   u0 : defaults (ACC_WIDTH=20, wrap)
//   u1 : ACC_WIDTH=17, wrap
//   u2 : ACC_WIDTH=17, saturate
// All three have identical handshake timing because overflow never affects
// flow control, so the shared out_ready/in_valid drive is consistent.
// -----------------------------------------------------------------------------
module tb_mac_dot_pipe;

  localparam int WA = 9;
  localparam int WB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_last;
  logic          out_ready;
  logic [WA-1:0] dataa;
  logic [WB-1:0] datab;

  logic          ir0, ir1, ir2;
  logic          ov0, ov1, ov2;
  logic [19:0]   res0;
  logic [16:0]   res1, res2;
  logic          ovf0, ovf1, ovf2;

  always #5 clk = ~clk;

  mac_dot_pipe #(.LPM_WIDTHA(WA), .LPM_WIDTHB(WB), .ACC_WIDTH(20), .DOT_LEN(4), .SATURATE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .dataa(dataa), .datab(datab),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .result(res0), .overflow(ovf0));

  mac_dot_pipe #(.LPM_WIDTHA(WA), .LPM_WIDTHB(WB), .ACC_WIDTH(17), .DOT_LEN(4), .SATURATE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .dataa(dataa), .datab(datab),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .result(res1), .overflow(ovf1));

  mac_dot_pipe #(.LPM_WIDTHA(WA), .LPM_WIDTHB(WB), .ACC_WIDTH(17), .DOT_LEN(4), .SATURATE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .dataa(dataa), .datab(datab),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .result(res2), .overflow(ovf2));

  // Results consumed by the sink, captured as {overflow, result}.
  logic [20:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] q2[$];

  always @(negedge clk) begin
    if (ov0 && out_ready) q0.push_back({ovf0, res0});
    if (ov1 && out_ready) q1.push_back({ovf1, res1});
    if (ov2 && out_ready) q2.push_back({ovf2, res2});
  end

  int tests = 0;
  int fails = 0;

  // Reference model state for the random phase.
  logic [20:0] e0[$];
  logic [17:0] e1[$];
  logic [17:0] e2[$];
  int          msum;
  int          mcnt;
  int          prod;
  logic        acc_now;
  logic        last_now;
  logic        big;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one term and hold it until accepted (bounded).
  task automatic send(input int a, input int b, input logic last);
    in_valid = 1'b1;
    dataa    = WA'(a);
    datab    = WB'(b);
    in_last  = last;
    #1;
    for (int i = 0; i < 100 && !ir0; i++) tick();
    if (!ir0) chk("send_in_ready", 32'(ir0), 32'd1);
    else tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop0(input string tag, input int r, input logic o);
    for (int i = 0; i < 60 && q0.size() == 0; i++) tick();
    if (q0.size() == 0) chk({tag, "_timeout"}, 32'(q0.size()), 32'd1);
    else chk(tag, 32'(q0.pop_front()), (32'(o) << 20) | 32'(r));
  endtask

  task automatic pop1(input string tag, input int r, input logic o);
    for (int i = 0; i < 60 && q1.size() == 0; i++) tick();
    if (q1.size() == 0) chk({tag, "_timeout"}, 32'(q1.size()), 32'd1);
    else chk(tag, 32'(q1.pop_front()), (32'(o) << 17) | 32'(r));
  endtask

  task automatic pop2(input string tag, input int r, input logic o);
    for (int i = 0; i < 60 && q2.size() == 0; i++) tick();
    if (q2.size() == 0) chk({tag, "_timeout"}, 32'(q2.size()), 32'd1);
    else chk(tag, 32'(q2.pop_front()), (32'(o) << 17) | 32'(r));
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    dataa     = '0;
    datab     = '0;
    out_ready = 1'b1;

    // Reset state, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_result",    32'(res0), 32'd0);
    chk("rst_overflow",  32'(ovf0), 32'd0);
    chk("rst_in_ready0", 32'(ir0), 32'd1);
    chk("rst_in_ready1", 32'(ir1), 32'd1);
    chk("rst_in_ready2", 32'(ir2), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1*2+3*4+5*6+7*8 = 100, out_valid exactly one cycle, two edges after
    // the fourth accept.
    for (int i = 0; i < 4; i++) send(2*i + 1, 2*i + 2, 1'b0);
    idle();
    chk("b2b_ov_n0", 32'(ov0), 32'd0);
    tick();
    chk("b2b_ov_n1", 32'(ov0), 32'd0);
    tick();
    chk("b2b_ov_n2",  32'(ov0), 32'd1);
    chk("b2b_result", 32'(res0), 32'd100);
    chk("b2b_ovf",    32'(ovf0), 32'd0);
    tick();
    chk("b2b_ov_n3", 32'(ov0), 32'd0);
    pop0("b2b_q0", 100, 1'b0);
    pop1("b2b_q1", 100, 1'b0);
    pop2("b2b_q2", 100, 1'b0);

    // Four (511,255): 4*130305 = 521220. 17-bit wrap: 521220-3*131072 = 128004.
    for (int i = 0; i < 4; i++) send(511, 255, 1'b0);
    idle();
    pop0("max_u0",   521220, 1'b0);
    pop1("max_wrap", 128004, 1'b1);
    pop2("max_sat",  131071, 1'b1);

    // Early termination: 10*10+20*1 = 120, then four (1,1) = 4.
    send(10, 10, 1'b0);
    send(20, 1, 1'b1);
    for (int i = 0; i < 4; i++) send(1, 1, 1'b0);
    idle();
    pop0("last_120", 120, 1'b0);
    pop0("last_4",   4,   1'b0);

    // Backpressure: 3*(3*3)+1*1 = 28 held while out_ready=0.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3, 3, 1'b0);
    send(1, 1, 1'b1);
    idle();
    for (int i = 0; i < 20 && !ov0; i++) tick();
    chk("bp_pending", 32'(ov0), 32'd1);
    in_valid = 1'b1;
    dataa    = WA'(5);
    datab    = WB'(5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(ir0), 32'd0);
      chk("bp_result",   32'(res0), 32'd28);
      tick();
    end
    chk("bp_none_consumed", 32'(q0.size()), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(5, 5, 1'b0);
    idle();
    pop0("bp_28",  28,  1'b0);
    pop0("bp_100", 100, 1'b0);

    // Reset mid-stream with a result pending and two terms in flight.
    for (int i = 0; i < 6; i++) send(2, 2, 1'b0);
    idle();
    chk("rm_pre_ov",  32'(ov0), 32'd1);
    chk("rm_pre_res", 32'(res0), 32'd16);
    rst_n = 1'b0;
    #1;
    chk("rm_out_valid", 32'(ov0), 32'd0);
    chk("rm_result",    32'(res0), 32'd0);
    chk("rm_overflow",  32'(ovf0), 32'd0);
    chk("rm_in_ready",  32'(ir0), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rm_dropped", 32'(q0.size()), 32'd0);
    for (int i = 0; i < 4; i++) send(2, 2, 1'b0);
    idle();
    pop0("rm_16", 16, 1'b0);

    // Random handshake stress against a reference model.
    repeat (3) tick();
    q0.delete();
    q1.delete();
    q2.delete();
    msum = 0;
    mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      dataa     = WA'($urandom_range(0, 511));
      datab     = WB'($urandom_range(0, 255));
      in_last   = ($urandom_range(0, 7) == 0);
      #1;
      acc_now  = in_valid && ir0;
      last_now = in_last;
      prod     = int'(dataa) * int'(datab);
      tick();
      if (acc_now) begin
        msum += prod;
        if (mcnt == 3 || last_now) begin
          big = (msum >= 131072);
          e0.push_back(21'(msum));
          e1.push_back({big, 17'(msum)});
          e2.push_back({big, big ? 17'h1FFFF : 17'(msum)});
          msum = 0;
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q0.size() < e0.size(); i++) tick();
    tick();
    chk("rnd_count_u0", 32'(q0.size()), 32'(e0.size()));
    chk("rnd_count_u1", 32'(q1.size()), 32'(e1.size()));
    chk("rnd_count_u2", 32'(q2.size()), 32'(e2.size()));
    for (int i = 0; i < e0.size() && i < q0.size(); i++) chk("rnd_u0", 32'(q0[i]), 32'(e0[i]));
    for (int i = 0; i < e1.size() && i < q1.size(); i++) chk("rnd_u1", 32'(q1[i]), 32'(e1[i]));
    for (int i = 0; i < e2.size() && i < q2.size(); i++) chk("rnd_u2", 32'(q2[i]), 32'(e2[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
